// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction-fetch controller between the IF stage and a
// direct-mapped instruction cache backed by a byte-wide memory controller.
// A request is first looked up in the cache (same-cycle hit response). A hit
// is returned one cycle later. On a miss the four bytes of the word are read
// sequentially from memory, assembled little-endian, returned to IF and
// written into the cache through its fill port.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global freeze when 0)
//   req_valid_i/req_addr_i      : IF request (held until inst_valid_o)
//   flush_i                     : branch redirect, aborts the current fetch
//   inst_valid_o/inst_o         : one-cycle instruction return
//   cache_query_o/query_addr_o  : combinational cache lookup
//   cache_hit_i/cache_inst_i    : cache lookup response
//   cache_enable_o/addr/data    : one-cycle cache fill strobe
//   mem_req_o/mem_addr_o        : registered byte read request
//   mem_busy_i                  : request this cycle not accepted
//   mem_din_i                   : byte returned the cycle after acceptance
module inst_fetcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  flush_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  cache_query_o,
  output logic [ADDR_WIDTH-1:0] query_addr_o,
  input  logic                  cache_hit_i,
  input  logic [INST_WIDTH-1:0] cache_inst_i,
  output logic                  cache_enable_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic [INST_WIDTH-1:0] cache_data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_busy_i,
  input  logic [7:0]            mem_din_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;  // word-aligned address of the miss
  logic [2:0]            r_ic;    // byte requests accepted so far (0..4)
  logic [1:0]            r_rc;    // bytes received so far
  logic                  r_acc;   // a request was accepted last cycle
  logic [INST_WIDTH-1:0] r_buf;   // assembly buffer, little-endian

  logic                  w_query;
  logic                  w_accept;
  logic [2:0]            w_next_ic;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [INST_WIDTH-1:0] w_word;

  // The valid cycle blocks a new lookup so IF can retire the returned
  // instruction and change its request before the next query.
  assign w_query = req_valid_i && (r_state == S_IDLE) && !inst_valid_o &&
                   !flush_i && rst && rdy;

  assign cache_query_o = w_query;
  assign query_addr_o  = req_addr_i;

  assign w_accept  = mem_req_o && !mem_busy_i;
  assign w_next_ic = r_ic + 3'd1;
  assign w_aligned = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};

  // Top byte of r_buf is still zero when the last byte arrives, so the final
  // word is the buffer with the incoming byte OR-ed into the top lane.
  assign w_word = r_buf | (INST_WIDTH'(mem_din_i) << (INST_WIDTH - 8));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_ic           <= '0;
      r_rc           <= '0;
      r_acc          <= 1'b0;
      r_buf          <= '0;
      inst_valid_o   <= 1'b0;
      inst_o         <= '0;
      cache_enable_o <= 1'b0;
      cache_addr_o   <= '0;
      cache_data_o   <= '0;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= '0;
    end else if (rdy) begin
      // Return and fill strobes are single-cycle pulses.
      inst_valid_o   <= 1'b0;
      cache_enable_o <= 1'b0;

      if (flush_i) begin
        // Redirect wins over hits and completions; late bytes are dropped
        // because r_acc is cleared.
        r_state   <= S_IDLE;
        mem_req_o <= 1'b0;
        r_acc     <= 1'b0;
        r_ic      <= '0;
        r_rc      <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_query) begin
              if (cache_hit_i) begin
                inst_o       <= cache_inst_i;
                inst_valid_o <= 1'b1;
              end else begin
                r_base     <= w_aligned;
                r_ic       <= '0;
                r_rc       <= '0;
                r_acc      <= 1'b0;
                r_buf      <= '0;
                mem_req_o  <= 1'b1;
                mem_addr_o <= w_aligned;
                r_state    <= S_FETCH;
              end
            end
          end

          S_FETCH: begin
            r_acc <= w_accept;
            // Busy: mem_addr_o is simply left alone and re-presented.
            if (w_accept) begin
              r_ic <= w_next_ic;
              if (w_next_ic == 3'd4) begin
                mem_req_o <= 1'b0;
              end else begin
                mem_addr_o <= r_base + ADDR_WIDTH'(w_next_ic);
              end
            end
            if (r_acc) begin
              r_buf[{r_rc, 3'b000} +: 8] <= mem_din_i;
              r_rc <= r_rc + 2'd1;
              if (r_rc == 2'd3) begin
                inst_valid_o   <= 1'b1;
                inst_o         <= w_word;
                cache_enable_o <= 1'b1;
                cache_addr_o   <= r_base;
                cache_data_o   <= w_word;
                r_state        <= S_DONE;
              end
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;
  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rdy = 1'b1;
  logic          req_valid_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic          flush_i = 1'b0;
  logic          cache_hit_i = 1'b0;
  logic [IW-1:0] cache_inst_i = '0;
  logic          mem_busy_i = 1'b0;
  logic [7:0]    mem_din_i = '0;

  logic          inst_valid_o;
  logic [IW-1:0] inst_o;
  logic          cache_query_o;
  logic [AW-1:0] query_addr_o;
  logic          cache_enable_o;
  logic [AW-1:0] cache_addr_o;
  logic [IW-1:0] cache_data_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;

  inst_fetcher #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .flush_i(flush_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o),
    .cache_query_o(cache_query_o), .query_addr_o(query_addr_o),
    .cache_hit_i(cache_hit_i), .cache_inst_i(cache_inst_i),
    .cache_enable_o(cache_enable_o), .cache_addr_o(cache_addr_o),
    .cache_data_o(cache_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_busy_i(mem_busy_i), .mem_din_i(mem_din_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0]    exp_inst_q[$];
  logic [AW+IW-1:0] exp_fill_q[$];

  bit rand_en   = 1'b0;
  bit force_rdy = 1'b0;

  // Direct-mapped cache model: 8 lines indexed by addr[4:2].
  bit          mv[8];
  logic [26:0] mtag[8];

  // Memory contents: fixed word at 0x1004, hashed bytes elsewhere.
  function automatic logic [7:0] membyte(input logic [31:0] a);
    case (a)
      32'h1004: return 8'h13;
      32'h1005: return 8'h05;
      32'h1006: return 8'h10;
      32'h1007: return 8'h00;
      default:  return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = membyte(a + 32'(i));
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rand_en) begin
      mem_busy_i = ($urandom_range(0, 3) == 0);
      rdy        = force_rdy ? 1'b1 : ($urandom_range(0, 7) != 0);
    end
  endtask

  // Memory controller: a request accepted in a cycle returns its byte in
  // the next cycle; the byte stays on the bus until the next acceptance.
  task automatic mem_loop();
    logic        acc;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #3;
      acc = rst && rdy && mem_req_o && !mem_busy_i;
      a   = mem_addr_o;
      @(posedge clk);
      #1;
      if (acc) mem_din_i = membyte(a);
    end
  endtask

  // Scoreboard monitor: consumes each returned instruction / fill once,
  // in a cycle where the design is not frozen.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      #2;
      if (rst && rdy) begin
        if (inst_valid_o) begin
          if (exp_inst_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_inst: got %0h expected none", inst_o);
          end else begin
            check("sb_inst", 64'(inst_o), 64'(exp_inst_q.pop_front()));
          end
        end
        if (cache_enable_o) begin
          if (exp_fill_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_fill: got %0h/%0h expected none", cache_addr_o, cache_data_o);
          end else begin
            check("sb_fill", {cache_addr_o, cache_data_o}, exp_fill_q.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr, al, word;
    int          idx;
    bit          hit, doflush, got, any_out;

    fork
      mem_loop();
      monitor_loop();
    join_none

    // Reset state
    repeat (3) step();
    req_valid_i = 1'b1;
    #1;
    check("rst_query", cache_query_o, 0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_cen", cache_enable_o, 0);
    check("rst_caddr", cache_addr_o, 0);
    check("rst_cdata", cache_data_o, 0);
    check("rst_mreq", mem_req_o, 0);
    check("rst_maddr", mem_addr_o, 0);
    req_valid_i = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Hit path
    step();
    req_addr_i = 32'h1004; cache_hit_i = 1'b1; cache_inst_i = 32'h00100513;
    req_valid_i = 1'b1;
    exp_inst_q.push_back(memword(32'h1004));
    #1;
    check("hit_query", cache_query_o, 1);
    check("hit_qaddr", query_addr_o, 32'h1004);
    step(); #1;
    check("hit_valid", inst_valid_o, 1);
    check("hit_inst", inst_o, 32'h00100513);
    check("hit_noquery", cache_query_o, 0);
    check("hit_nomreq", mem_req_o, 0);
    req_valid_i = 1'b0; cache_hit_i = 1'b0;
    step(); #1;
    check("hit_pulse", inst_valid_o, 0);

    // Miss fill, req dropped mid-fetch
    step();
    req_addr_i = 32'h1006; req_valid_i = 1'b1;
    exp_inst_q.push_back(memword(32'h1004));
    exp_fill_q.push_back({32'h1004, memword(32'h1004)});
    #1;
    check("miss_query", cache_query_o, 1);
    for (int k = 1; k <= 7; k++) begin
      step(); #1;
      if (k == 2) req_valid_i = 1'b0;
      if (k <= 4) begin
        check("miss_mreq", mem_req_o, 1);
        check("miss_maddr", mem_addr_o, 32'h1004 + 32'(k - 1));
      end
      if (k == 5) begin
        check("miss_mreq_off", mem_req_o, 0);
        check("miss_early", inst_valid_o, 0);
      end
      if (k == 6) begin
        check("miss_valid", inst_valid_o, 1);
        check("miss_inst", inst_o, 32'h00100513);
        check("miss_cen", cache_enable_o, 1);
        check("miss_caddr", cache_addr_o, 32'h1004);
        check("miss_cdata", cache_data_o, 32'h00100513);
      end
      if (k == 7) check("miss_pulse", {inst_valid_o, cache_enable_o}, 0);
    end

    // Busy stall on the byte-2 request
    step();
    req_addr_i = 32'h1006; req_valid_i = 1'b1;
    exp_inst_q.push_back(memword(32'h1004));
    exp_fill_q.push_back({32'h1004, memword(32'h1004)});
    for (int k = 1; k <= 9; k++) begin
      step();
      mem_busy_i = (k >= 3 && k <= 5);
      #1;
      if (k >= 3 && k <= 6) check("busy_hold", mem_addr_o, 32'h1006);
      if (k == 7) check("busy_next", mem_addr_o, 32'h1007);
      if (k == 8) check("busy_early", inst_valid_o, 0);
      if (k == 9) begin
        check("busy_valid", inst_valid_o, 1);
        check("busy_inst", inst_o, 32'h00100513);
        req_valid_i = 1'b0;
      end
    end

    // rdy gating
    step();
    req_addr_i = 32'h1006; req_valid_i = 1'b1; rdy = 1'b0;
    #1;
    check("rdy_noquery", cache_query_o, 0);
    step();
    rdy = 1'b1;
    exp_inst_q.push_back(memword(32'h1004));
    exp_fill_q.push_back({32'h1004, memword(32'h1004)});
    #1;
    check("rdy_query", cache_query_o, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      rdy = !(k == 2 || k == 3);
      #1;
      if (k >= 2 && k <= 4) check("rdy_hold", mem_addr_o, 32'h1005);
      if (k == 3) check("rdy_query_off", cache_query_o, 0);
      if (k == 5) check("rdy_next", mem_addr_o, 32'h1006);
      if (k == 7) check("rdy_early", inst_valid_o, 0);
      if (k == 8) begin
        check("rdy_valid", inst_valid_o, 1);
        check("rdy_inst", inst_o, 32'h00100513);
        req_valid_i = 1'b0;
      end
    end
    step();

    // Flush mid-fetch after byte 1 received
    step();
    req_addr_i = 32'h1006; req_valid_i = 1'b1;
    #1;
    check("fl_query", cache_query_o, 1);
    for (int k = 1; k <= 4; k++) step();
    flush_i = 1'b1; req_valid_i = 1'b0;
    step();
    flush_i = 1'b0;
    #1;
    check("fl_mreq", mem_req_o, 0);
    check("fl_valid", inst_valid_o, 0);
    check("fl_cen", cache_enable_o, 0);
    any_out = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      any_out = any_out | inst_valid_o | cache_enable_o;
    end
    check("fl_no_out", any_out, 0);
    step();
    req_addr_i = 32'h2000; req_valid_i = 1'b1;
    cache_hit_i = 1'b1; cache_inst_i = memword(32'h2000);
    exp_inst_q.push_back(memword(32'h2000));
    #1;
    check("fl_newquery", cache_query_o, 1);
    check("fl_newqaddr", query_addr_o, 32'h2000);
    step(); #1;
    check("fl_newvalid", inst_valid_o, 1);
    req_valid_i = 1'b0; cache_hit_i = 1'b0;

    // Reset mid-fetch
    step();
    req_addr_i = 32'h1006; req_valid_i = 1'b1;
    for (int k = 1; k <= 3; k++) step();
    rst = 1'b0; req_valid_i = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rm_valid", inst_valid_o, 0);
    check("rm_inst", inst_o, 0);
    check("rm_cen", cache_enable_o, 0);
    check("rm_caddr", cache_addr_o, 0);
    check("rm_cdata", cache_data_o, 0);
    check("rm_mreq", mem_req_o, 0);
    check("rm_maddr", mem_addr_o, 0);
    any_out = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      any_out = any_out | inst_valid_o | cache_enable_o | mem_req_o;
    end
    check("rm_no_out", any_out, 0);

    // Randomized traffic against the cache/memory model
    rand_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) step();
      idx  = $urandom_range(0, 7);
      addr = ($urandom_range(0, 1) != 0 ? 32'h5000 : 32'h3000) + 32'(idx * 4) + 32'($urandom_range(0, 3));
      al   = {addr[31:2], 2'b00};
      word = memword(al);
      hit  = mv[idx] && (mtag[idx] == al[31:5]);
      step();
      req_addr_i = addr; req_valid_i = 1'b1; cache_hit_i = hit;
      cache_inst_i = hit ? word : $urandom;
      exp_inst_q.push_back(word);
      if (!hit) exp_fill_q.push_back({al, word});
      doflush = !hit && ($urandom_range(0, 4) == 0);
      if (doflush) begin
        repeat ($urandom_range(1, 3)) step();
        force_rdy = 1'b1;
        step();
        flush_i = 1'b1; req_valid_i = 1'b0;
        void'(exp_inst_q.pop_back());
        void'(exp_fill_q.pop_back());
        step();
        flush_i = 1'b0; force_rdy = 1'b0;
      end else begin
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
          step(); #1;
          if (inst_valid_o && rdy) got = 1'b1;
        end
        req_valid_i = 1'b0;
        if (!got) begin
          total++; bad++;
          $display("FAIL rand_timeout: got no inst expected %0h", word);
        end else if (!hit) begin
          mv[idx]   = 1'b1;
          mtag[idx] = al[31:5];
        end
      end
    end

    rand_en = 1'b0; rdy = 1'b1; mem_busy_i = 1'b0;
    repeat (5) step();
    check("sb_drained", 64'(exp_inst_q.size() + exp_fill_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
